rst_seq_ctrl: RTL and testbench

Reset sequencer that owns the release order of several downstream reset domains.
- Holds every domain in reset for a minimum time.
- Then releases the domains one at a time, in index order 0..N_DOM-1.
- After each release, waits for that domain's ready acknowledge (or a timeout) and a programmable gap before releasing the next domain.
- Each o_dom_rst_n bit drives the async input of that domain's reset synchronizer. A software request re-runs the whole sequence.

---
 rtl/rst_seq_ctrl.sv | 171 +++++++++++++++++
 tb/tb_rst_seq_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds all downstream domains in reset, then releases them
// one by one in index order, waiting for each domain's ack (or a timeout) plus a gap.
module rst_seq_ctrl #(
  parameter int N_DOM    = 4,
  parameter int HOLD_CYC = 16,
  parameter int GAP_CYC  = 8,
  parameter int ACK_TO   = 255,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_sw_rst_req,
  input  logic [N_DOM-1:0] i_dom_ack,
  output logic [N_DOM-1:0] o_dom_rst_n,
  output logic             o_busy,
  output logic             o_seq_done,
  output logic [N_DOM-1:0] o_timeout
);

  localparam int IDX_W = (N_DOM > 1) ? $clog2(N_DOM) : 1;

  localparam logic [2:0] ST_HOLD = 3'd0;
  localparam logic [2:0] ST_REL  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_GAP  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);
  localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TO - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DOM - 1);
  localparam logic             GAP_EN    = (GAP_CYC > 0);

  // One-hot select of the domain currently being sequenced.
  function automatic logic [N_DOM-1:0] idx_mask(input logic [IDX_W-1:0] idx);
    logic [N_DOM-1:0] mask;
    for (int i = 0; i < N_DOM; i++) begin
      mask[i] = (idx == IDX_W'(i));
    end
    return mask;
  endfunction

  logic [2:0]       state_r;
  logic [2:0]       state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic [IDX_W-1:0] idx_r;
  logic [IDX_W-1:0] idx_s;
  logic [N_DOM-1:0] dom_rst_n_r;
  logic [N_DOM-1:0] dom_rst_n_s;
  logic [N_DOM-1:0] timeout_r;
  logic [N_DOM-1:0] timeout_s;
  logic             busy_r;
  logic             done_r;
  logic [N_DOM-1:0] cur_mask_s;
  logic             ack_cur_s;
  logic             proceed_s;

  // Current-domain select and its ack; acks of other domains are masked off.
  always_comb begin
    cur_mask_s = idx_mask(idx_r);
    ack_cur_s  = |(i_dom_ack & cur_mask_s);
  end

  // Next-state, counter, index and output-bit computation.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    idx_s       = idx_r;
    dom_rst_n_s = dom_rst_n_r;
    timeout_s   = timeout_r;
    proceed_s   = 1'b0;
    if (i_sw_rst_req) begin
      state_s     = ST_HOLD;
      cnt_s       = '0;
      idx_s       = '0;
      dom_rst_n_s = '0;
      timeout_s   = '0;
    end else begin
      case (state_r)
        ST_HOLD: begin
          dom_rst_n_s = '0;
          if (cnt_r == HOLD_LAST) begin
            cnt_s   = '0;
            idx_s   = '0;
            state_s = ST_REL;
          end else begin
            cnt_s = cnt_r + 1'b1;
          end
        end
        ST_REL: begin
          dom_rst_n_s = dom_rst_n_r | cur_mask_s;
          cnt_s       = '0;
          state_s     = ST_WAIT;
        end
        ST_WAIT: begin
          // Ack has priority over a timeout landing on the same cycle.
          if (ack_cur_s) begin
            proceed_s = 1'b1;
          end else if (cnt_r == ACK_LAST) begin
            timeout_s = timeout_r | cur_mask_s;
            proceed_s = 1'b1;
          end else begin
            cnt_s = cnt_r + 1'b1;
          end
          if (proceed_s) begin
            cnt_s = '0;
            if (idx_r == IDX_LAST) begin
              state_s = ST_DONE;
            end else if (!GAP_EN) begin
              idx_s   = idx_r + 1'b1;
              state_s = ST_REL;
            end else begin
              state_s = ST_GAP;
            end
          end else begin
            state_s = ST_WAIT;
          end
        end
        ST_GAP: begin
          if (cnt_r == GAP_LAST) begin
            cnt_s   = '0;
            idx_s   = idx_r + 1'b1;
            state_s = ST_REL;
          end else begin
            cnt_s = cnt_r + 1'b1;
          end
        end
        ST_DONE: begin
          state_s = ST_DONE;
        end
        default: begin
          // Unreachable encoding: fall back to a full, safe restart.
          state_s     = ST_HOLD;
          cnt_s       = '0;
          idx_s       = '0;
          dom_rst_n_s = '0;
          timeout_s   = '0;
        end
      endcase
    end
  end

  // State and registered outputs; status flags follow the next state so they
  // change on the same edge as the transition that causes them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_HOLD;
      cnt_r       <= '0;
      idx_r       <= '0;
      dom_rst_n_r <= '0;
      timeout_r   <= '0;
      busy_r      <= 1'b1;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      idx_r       <= idx_s;
      dom_rst_n_r <= dom_rst_n_s;
      timeout_r   <= timeout_s;
      busy_r      <= (state_s != ST_DONE);
      done_r      <= (state_s == ST_DONE);
    end
  end

  assign o_dom_rst_n = dom_rst_n_r;
  assign o_timeout   = timeout_r;
  assign o_busy      = busy_r;
  assign o_seq_done  = done_r;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: default 4-domain instance plus a
// 1-domain, no-gap, ACK_TO=1 corner instance sharing clock, reset and request.
module tb_rst_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       sw_req;
  logic [3:0] ack;
  logic [3:0] dom_rst_n;
  logic       busy;
  logic       seq_done;
  logic [3:0] timeout;
  logic [0:0] ack1;
  logic [0:0] dom_rst_n1;
  logic       busy1;
  logic       seq_done1;
  logic [0:0] timeout1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rst_seq_ctrl u_dut (
    .clk          (clk),
    .reset        (reset),
    .i_sw_rst_req (sw_req),
    .i_dom_ack    (ack),
    .o_dom_rst_n  (dom_rst_n),
    .o_busy       (busy),
    .o_seq_done   (seq_done),
    .o_timeout    (timeout)
  );

  rst_seq_ctrl #(
    .N_DOM    (1),
    .HOLD_CYC (16),
    .GAP_CYC  (0),
    .ACK_TO   (1),
    .CNT_W    (16)
  ) u_dut1 (
    .clk          (clk),
    .reset        (reset),
    .i_sw_rst_req (sw_req),
    .i_dom_ack    (ack1),
    .o_dom_rst_n  (dom_rst_n1),
    .o_busy       (busy1),
    .o_seq_done   (seq_done1),
    .o_timeout    (timeout1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic ticks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b0;
    sw_req = 1'b0;
    ack    = 4'hF;
    ack1   = 1'b0;
    #12;
    check_eq("por_rst_n", 32'(dom_rst_n), 32'h0);
    check_eq("por_busy", 32'(busy), 32'h1);
    check_eq("por_done", 32'(seq_done), 32'h0);
    check_eq("por_timeout", 32'(timeout), 32'h0);
    check_eq("por_rst_n1", 32'(dom_rst_n1), 32'h0);
    reset = 1'b1;

    // Power-on sequence with acks high: releases at edges 17/27/37/47, done at 48.
    ticks(16);
    check_eq("t1_e16", 32'(dom_rst_n), 32'h0);
    ticks(1);
    check_eq("t1_e17", 32'(dom_rst_n), 32'h1);
    check_eq("t6_rel", 32'(dom_rst_n1), 32'h1);
    check_eq("t6_to_pre", 32'(timeout1), 32'h0);
    ticks(1);
    check_eq("t6_to", 32'(timeout1), 32'h1);
    check_eq("t6_done", 32'(seq_done1), 32'h1);
    check_eq("t6_busy", 32'(busy1), 32'h0);
    ticks(8);
    check_eq("t1_e26", 32'(dom_rst_n), 32'h1);
    ticks(1);
    check_eq("t1_e27", 32'(dom_rst_n), 32'h3);
    ticks(10);
    check_eq("t1_e37", 32'(dom_rst_n), 32'h7);
    ticks(10);
    check_eq("t1_e47", 32'(dom_rst_n), 32'hF);
    check_eq("t1_e47_done", 32'(seq_done), 32'h0);
    check_eq("t1_e47_busy", 32'(busy), 32'h1);
    ticks(1);
    check_eq("t1_e48_done", 32'(seq_done), 32'h1);
    check_eq("t1_e48_busy", 32'(busy), 32'h0);
    ticks(3);
    check_eq("t1_hold_done", 32'(seq_done), 32'h1);

    // Request in DONE; corner instance gets ack high to exercise the tie.
    sw_req = 1'b1;
    ack    = 4'h0;
    ack1   = 1'b1;
    ticks(1);
    sw_req = 1'b0;
    check_eq("t4a_rst_n", 32'(dom_rst_n), 32'h0);
    check_eq("t4a_busy", 32'(busy), 32'h1);
    check_eq("t4a_done", 32'(seq_done), 32'h0);
    check_eq("t4a_to1_clr", 32'(timeout1), 32'h0);
    check_eq("t4a_rst_n1", 32'(dom_rst_n1), 32'h0);
    ticks(16);
    check_eq("t4a_q16", 32'(dom_rst_n), 32'h0);
    ticks(1);
    check_eq("t2_r0", 32'(dom_rst_n), 32'h1);
    ticks(1);
    check_eq("t6_tie_to", 32'(timeout1), 32'h0);
    check_eq("t6_tie_done", 32'(seq_done1), 32'h1);

    // Delayed acks 5,0,20,3 after release; next release at drive + GAP + 2.
    ticks(4);
    ack = 4'b0001;
    ticks(9);
    check_eq("t2_r1_pre", 32'(dom_rst_n), 32'h1);
    ticks(1);
    check_eq("t2_r1", 32'(dom_rst_n), 32'h3);
    ack = 4'b0011;
    ticks(9);
    check_eq("t2_r2_pre", 32'(dom_rst_n), 32'h3);
    ticks(1);
    check_eq("t2_r2", 32'(dom_rst_n), 32'h7);
    ack = 4'b1011;
    ticks(20);
    ack = 4'b1111;
    ticks(1);
    ack = 4'b0000;
    ticks(8);
    check_eq("t2_r3_pre", 32'(dom_rst_n), 32'h7);
    ticks(1);
    check_eq("t2_r3", 32'(dom_rst_n), 32'hF);
    ticks(3);
    ack = 4'b1000;
    check_eq("t2_done_pre", 32'(seq_done), 32'h0);
    ticks(1);
    check_eq("t2_done", 32'(seq_done), 32'h1);
    check_eq("t2_timeout", 32'(timeout), 32'h0);

    // Domain 2 never acks: timeout after 255 wait cycles, domain 3 still released.
    sw_req = 1'b1;
    ack    = 4'b1011;
    ticks(1);
    sw_req = 1'b0;
    ticks(37);
    check_eq("t3_r2", 32'(dom_rst_n), 32'h7);
    ticks(254);
    check_eq("t3_to_pre", 32'(timeout), 32'h0);
    ticks(1);
    check_eq("t3_to", 32'(timeout), 32'h4);
    ticks(8);
    check_eq("t3_r3_pre", 32'(dom_rst_n), 32'h7);
    ticks(1);
    check_eq("t3_r3", 32'(dom_rst_n), 32'hF);
    ticks(1);
    check_eq("t3_done", 32'(seq_done), 32'h1);
    check_eq("t3_to_keep", 32'(timeout), 32'h4);

    // Request in DONE clears timeout; second request lands in GAP after domain 1.
    sw_req = 1'b1;
    ack    = 4'hF;
    ticks(1);
    sw_req = 1'b0;
    check_eq("t4b_to_clr", 32'(timeout), 32'h0);
    check_eq("t4b_rst_n", 32'(dom_rst_n), 32'h0);
    ticks(27);
    check_eq("t4b_r1", 32'(dom_rst_n), 32'h3);
    ticks(2);
    sw_req = 1'b1;
    ticks(1);
    sw_req = 1'b0;
    check_eq("t4b_abort_rst_n", 32'(dom_rst_n), 32'h0);
    check_eq("t4b_abort_busy", 32'(busy), 32'h1);
    ticks(16);
    check_eq("t4b_q16", 32'(dom_rst_n), 32'h0);
    ticks(1);
    check_eq("t4b_rerel", 32'(dom_rst_n), 32'h1);

    // Async reset while waiting for domain 2's ack.
    ack = 4'b0011;
    ticks(20);
    check_eq("t5_r2", 32'(dom_rst_n), 32'h7);
    check_eq("t5_done1_pre", 32'(seq_done1), 32'h1);
    ticks(3);
    #3;
    reset = 1'b0;
    #1;
    check_eq("t5_async_rst_n", 32'(dom_rst_n), 32'h0);
    check_eq("t5_async_busy", 32'(busy), 32'h1);
    check_eq("t5_async_done1", 32'(seq_done1), 32'h0);
    check_eq("t5_async_busy1", 32'(busy1), 32'h1);
    #2;
    reset = 1'b1;
    ack   = 4'hF;
    ticks(16);
    check_eq("t5_e16", 32'(dom_rst_n), 32'h0);
    ticks(1);
    check_eq("t5_e17", 32'(dom_rst_n), 32'h1);
    ticks(31);
    check_eq("t5_e48_rst_n", 32'(dom_rst_n), 32'hF);
    check_eq("t5_e48_done", 32'(seq_done), 32'h1);
    check_eq("t5_timeout", 32'(timeout), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
